// File: rtl/event_counter_bank.sv
// event_counter_bank
// A bank of CHANNELS independent up/down counters, each WIDTH bits wide.
// Every channel can be cleared, loaded from a shared operand, incremented or
// decremented. A global mode selects wrap-around or saturating arithmetic.
//
// Ports:
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high reset
//   clear          per-channel clear to zero (highest priority)
//   load           per-channel load of load_value
//   load_value     shared load operand
//   inc, dec       per-channel step requests (both together = hold)
//   sat_mode       1 = saturate at the ends, 0 = wrap around
//   compare_value  shared threshold for the match flags
//   ovf_clear      per-channel clear of the sticky overflow flag
//   rd_sel         channel select for rd_count (out of range reads 0)
//   count_flat     all counts, channel i at [i*WIDTH +: WIDTH]
//   rd_count       combinational readback of the selected channel
//   match          combinational count == compare_value per channel
//   wrap_pulse     registered one-cycle flag on a wrap in wrap mode
//   ovf_sticky     registered sticky flag on any wrap or blocked step
module event_counter_bank #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       clear,
   input  logic [CHANNELS-1:0]       load,
   input  logic [WIDTH-1:0]          load_value,
   input  logic [CHANNELS-1:0]       inc,
   input  logic [CHANNELS-1:0]       dec,
   input  logic                      sat_mode,
   input  logic [WIDTH-1:0]          compare_value,
   input  logic [CHANNELS-1:0]       ovf_clear,
   input  logic [SEL_W-1:0]          rd_sel,
   output logic [CHANNELS*WIDTH-1:0] count_flat,
   output logic [WIDTH-1:0]          rd_count,
   output logic [CHANNELS-1:0]       match,
   output logic [CHANNELS-1:0]       wrap_pulse,
   output logic [CHANNELS-1:0]       ovf_sticky
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]    count_q    [CHANNELS];
   logic [WIDTH-1:0]    count_d    [CHANNELS];
   logic [CHANNELS-1:0] wrap_d;
   logic [CHANNELS-1:0] ovf_event;
   logic [CHANNELS-1:0] ovf_d;

   // Next-state logic per channel: clear beats load beats a single step.
   // A step that would cross an end of the range is an overflow event; in
   // wrap mode it wraps and pulses, in saturate mode the count just stays put.
   // The sticky flag is set by an event even if ovf_clear arrives together.
   always_comb begin
      wrap_d    = '0;
      ovf_event = '0;
      ovf_d     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         count_d[i] = count_q[i];
         if (clear[i]) begin
            count_d[i] = ZERO;
         end else if (load[i]) begin
            count_d[i] = load_value;
         end else if (inc[i] && !dec[i]) begin
            if (count_q[i] == ALL_ONES) begin
               ovf_event[i] = 1'b1;
               if (!sat_mode) begin
                  count_d[i] = ZERO;
                  wrap_d[i]  = 1'b1;
               end
            end else begin
               count_d[i] = count_q[i] + ONE;
            end
         end else if (dec[i] && !inc[i]) begin
            if (count_q[i] == ZERO) begin
               ovf_event[i] = 1'b1;
               if (!sat_mode) begin
                  count_d[i] = ALL_ONES;
                  wrap_d[i]  = 1'b1;
               end
            end else begin
               count_d[i] = count_q[i] - ONE;
            end
         end
         if (ovf_event[i]) begin
            ovf_d[i] = 1'b1;
         end else if (ovf_clear[i]) begin
            ovf_d[i] = 1'b0;
         end else begin
            ovf_d[i] = ovf_sticky[i];
         end
      end
   end

   // State registers; reset overrides every request in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            count_q[i] <= ZERO;
         end
         wrap_pulse <= '0;
         ovf_sticky <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            count_q[i] <= count_d[i];
         end
         wrap_pulse <= wrap_d;
         ovf_sticky <= ovf_d;
      end
   end

   // Flatten the counts, build match flags and the readback mux. The select
   // is widened before comparing so a narrow rd_sel never aliases a channel,
   // and any select past the last channel reads back zero.
   always_comb begin
      rd_count = ZERO;
      for (int i = 0; i < CHANNELS; i++) begin
         count_flat[i*WIDTH +: WIDTH] = count_q[i];
         match[i] = (count_q[i] == compare_value);
         if (32'(rd_sel) == i) begin
            rd_count = count_q[i];
         end
      end
   end

endmodule

// File: doc/event_counter_bank.md
EVENT_COUNTER_BANK -- requirements
Module: event_counter_bank

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter CHANNELS, default 4: number of independent counters, legal range 1..16.
REQ-003 Parameter SEL_W, default 2: read-select width; SHALL be at least ceil(log2(CHANNELS)), minimum 1.
REQ-004 clk  input  1: rising-edge clock for all state.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 clear  input  CHANNELS: per-channel synchronous clear request.
REQ-007 load  input  CHANNELS: per-channel load request, using load_value.
REQ-008 load_value  input  WIDTH: shared load operand.
REQ-009 inc  input  CHANNELS: per-channel increment request.
REQ-010 dec  input  CHANNELS: per-channel decrement request.
REQ-011 sat_mode  input  1: global mode; 1 = saturate, 0 = wrap.
REQ-012 compare_value  input  WIDTH: shared match threshold.
REQ-013 ovf_clear  input  CHANNELS: per-channel clear for the sticky overflow flag.
REQ-014 rd_sel  input  SEL_W: channel select for rd_count.
REQ-015 count_flat  output  CHANNELS*WIDTH: all counters; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-016 rd_count  output  WIDTH: combinational mux of the selected channel's count.
REQ-017 match  output  CHANNELS: combinational flag, high when count equals compare_value.
REQ-018 wrap_pulse  output  CHANNELS: registered single-cycle wrap event flag.
REQ-019 ovf_sticky  output  CHANNELS: registered sticky overflow/underflow flag.

Function
REQ-020 Each channel SHALL update on every rising clk edge by the following priority, highest first: clear, load, inc/dec, hold.
REQ-021 A clear SHALL set the next count to 0.
REQ-022 A load SHALL set the next count to load_value.
REQ-023 When inc and dec are asserted in the same cycle, the count SHALL hold.
REQ-024 inc alone SHALL set count+1; dec alone SHALL set count-1; all arithmetic is modulo 2^WIDTH.
REQ-025 In wrap mode, inc at all-ones (2^WIDTH-1) SHALL produce 0.
REQ-026 In wrap mode, dec at 0 SHALL produce all-ones.
REQ-027 Each wrap in wrap mode SHALL assert wrap_pulse[i] for exactly one cycle, coincident with the new count.
REQ-028 In saturate mode, inc at all-ones SHALL hold all-ones, and dec at 0 SHALL hold 0.
REQ-029 In saturate mode, wrap_pulse SHALL remain low.
REQ-030 Any wrap or saturation-blocked step (overflow event) SHALL set ovf_sticky[i] on the same edge.
REQ-031 ovf_sticky[i] SHALL clear on ovf_clear[i], except that a same-cycle overflow event wins and sets the flag.
REQ-032 clear and load SHALL never generate an overflow event and SHALL not alter ovf_sticky.
REQ-033 Channels SHALL be fully independent; no request on one channel affects another.
REQ-034 A rd_sel value of CHANNELS or greater SHALL return 0 on rd_count.
REQ-035 A change to sat_mode SHALL take effect on the next edge; no state is flushed on a mode change.

Reset
REQ-036 While reset is high at a clk edge, all counts, wrap_pulse and ovf_sticky SHALL become 0, overriding all other inputs.
REQ-037 Reset asserted mid-operation SHALL discard any pending request in that cycle.
REQ-038 Counting SHALL resume on the first edge after reset deasserts.
REQ-039 After reset, match SHALL reflect (0 == compare_value).

Verification
REQ-040 Wrap up: WIDTH=8, sat_mode=0, load 0xFE then inc x2 -> counts 0xFF then 0x00; wrap_pulse high one cycle with 0x00; ovf_sticky=1.
REQ-041 Saturate: sat_mode=1, load 0x01, dec x3 -> 0x00, 0x00, 0x00; wrap_pulse stays 0; ovf_sticky set on the second dec.
REQ-042 Priority: count=0x10, clear+load(0x55)+inc same cycle -> 0x00; load(0x55)+inc -> 0x55; inc+dec -> hold 0x55.
REQ-043 Sticky race: ovf_clear asserted on the same edge as a wrap -> ovf_sticky stays 1; next cycle ovf_clear alone -> 0.
REQ-044 Independence/readback: CHANNELS=4, inc channel 2 only x5 -> count_flat ch2=5, others 0; rd_sel=2 -> rd_count=5; rd_sel=3 -> 0; compare_value=5 -> match=4'b0100.
REQ-045 Reset mid-run: ch0=0x80 with inc held, assert reset one cycle -> all counts 0, flags 0; next edge with inc -> 0x01.
